y86_fetch_decode: RTL and testbench



---
 rtl/y86_pkg.sv | 55 +++++
 rtl/y86_regfile.sv | 44 ++++
 rtl/y86_fetch_decode.sv | 130 +++++++++++++
 tb/tb_y86_fetch_decode.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Y86-64 front-end shared definitions: icodes, register ids, status codes, fetch record.
// Pure definitions; no latency, no backpressure.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    typedef enum logic [2:0] {
        SAOK = 3'd1,
        SHLT = 3'd2,
        SADR = 3'd3,
        SINS = 3'd4
    } stat_t;

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        stat_t       stat;
    } fetch_t;

    // Invalid icodes fall to the default and are treated as one byte long.
    function automatic logic [3:0] instr_len(input logic [3:0] ic);
        case (ic)
            IIRMOVQ, IRMMOVQ, IMRMOVQ:         return 4'd10;
            IJXX, ICALL:                       return 4'd9;
            IRRMOVQ, IOPQ, IPUSHQ, IPOPQ:      return 4'd2;
            default:                           return 4'd1;
        endcase
    endfunction

    function automatic logic has_regs(input logic [3:0] ic);
        case (ic)
            IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IPUSHQ, IPOPQ: return 1'b1;
            default:                                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/y86_regfile.sv
// 15 x 64-bit Y86 register file, two combinational read ports (index F reads 0), one write port.
// Reads are same-cycle with no write bypass; writes land on the rising edge; no backpressure.
module y86_regfile
    import y86_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [3:0]    waddr_i,
    input  logic [63:0]   wdata_i,
    input  logic [3:0]    raddr_a_i,
    input  logic [3:0]    raddr_b_i,
    output logic [63:0]   rdata_a_o,
`ifdef REGDUMP_EN
    output logic [1023:0] dump_o,
`endif
    output logic [63:0]   rdata_b_o
);

    logic [63:0] regs_q [15];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) begin
                regs_q[i] <= 64'(i);
            end
        end else if (we_i && (waddr_i != RNONE)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == RNONE) ? 64'd0 : regs_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == RNONE) ? 64'd0 : regs_q[raddr_b_i];

`ifdef REGDUMP_EN
    always_comb begin
        dump_o = '0;
        for (int i = 0; i < 15; i++) begin
            dump_o[64*i +: 64] = regs_q[i];
        end
    end
`endif

endmodule

// File: rtl/y86_fetch_decode.sv
// Y86-64 fetch (registered, 1-cycle pc->fields) plus combinational decode; no backpressure.
// Define REGDUMP_EN to expose all registers on reg_dump for debug.
module y86_fetch_decode
    import y86_pkg::*;
#(
    parameter int IMEM_BYTES = 1024,
    parameter int IMEM_AW    = $clog2(IMEM_BYTES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [63:0]        pc,
    input  logic               imem_we,
    input  logic [IMEM_AW-1:0] imem_addr,
    input  logic [7:0]         imem_wdata,
    input  logic               rf_we,
    input  logic [3:0]         rf_waddr,
    input  logic [63:0]        rf_wdata,
    output logic [3:0]         icode,
    output logic [3:0]         ifun,
    output logic [3:0]         rA,
    output logic [3:0]         rB,
    output logic [63:0]        valC,
    output logic [63:0]        valP,
    output logic [63:0]        valA,
    output logic [63:0]        valB,
`ifdef REGDUMP_EN
    output logic [1023:0]      reg_dump,
`endif
    output logic [2:0]         stat
);

    logic [7:0]  imem [IMEM_BYTES];
    logic [7:0]  fb [10];
    logic [3:0]  len;
    logic        adr;
    fetch_t      f_d;
    fetch_t      f_q;
    logic [3:0]  src_a;
    logic [3:0]  src_b;

    // Program-load port; deliberately outside reset so contents survive it.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_addr] <= imem_wdata;
        end
    end

    always_comb begin
        for (int k = 0; k < 10; k++) begin
            fb[k] = imem[pc[IMEM_AW-1:0] + IMEM_AW'(k)];
        end
        len       = instr_len(fb[0][7:4]);
        f_d.icode = fb[0][7:4];
        f_d.ifun  = fb[0][3:0];
        f_d.ra    = RNONE;
        f_d.rb    = RNONE;
        f_d.valc  = 64'd0;
        if (has_regs(f_d.icode)) begin
            {f_d.ra, f_d.rb} = fb[1];
        end
        case (f_d.icode)
            IIRMOVQ, IRMMOVQ, IMRMOVQ:
                f_d.valc = {fb[9], fb[8], fb[7], fb[6], fb[5], fb[4], fb[3], fb[2]};
            IJXX, ICALL:
                f_d.valc = {fb[8], fb[7], fb[6], fb[5], fb[4], fb[3], fb[2], fb[1]};
            default: ;
        endcase
        f_d.valp = pc + 64'(len);
        // 65-bit compare so a pc near 2^64 cannot wrap back into range.
        adr = ({1'b0, pc} + 65'(len)) > 65'(IMEM_BYTES);
        if (adr) begin
            f_d.stat = SADR;
            f_d.valc = 64'd0;
        end else if (f_d.icode > IPOPQ) begin
            f_d.stat = SINS;
        end else if (f_d.icode == IHALT) begin
            f_d.stat = SHLT;
        end else begin
            f_d.stat = SAOK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q <= '{icode: INOP, ifun: 4'h0, ra: RNONE, rb: RNONE,
                     valc: 64'd0, valp: 64'd0, stat: SAOK};
        end else begin
            f_q <= f_d;
        end
    end

    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        case (f_q.icode)
            IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: src_a = f_q.ra;
            IRET, IPOPQ:                    src_a = RRSP;
            default: ;
        endcase
        case (f_q.icode)
            IRMMOVQ, IMRMOVQ, IOPQ:         src_b = f_q.rb;
            ICALL, IRET, IPUSHQ, IPOPQ:     src_b = RRSP;
            default: ;
        endcase
    end

    y86_regfile u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (rf_we),
        .waddr_i   (rf_waddr),
        .wdata_i   (rf_wdata),
        .raddr_a_i (src_a),
        .raddr_b_i (src_b),
        .rdata_a_o (valA),
`ifdef REGDUMP_EN
        .dump_o    (reg_dump),
`endif
        .rdata_b_o (valB)
    );

    assign icode = f_q.icode;
    assign ifun  = f_q.ifun;
    assign rA    = f_q.ra;
    assign rB    = f_q.rb;
    assign valC  = f_q.valc;
    assign valP  = f_q.valp;
    assign stat  = f_q.stat;

endmodule

// File: tb/tb_y86_fetch_decode.sv
// Scoreboarded bench for y86_fetch_decode: expected decode records are queued when pc is driven.
module tb_y86_fetch_decode;

    localparam int IMEM_BYTES = 1024;
    localparam int IMEM_AW    = 10;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic [63:0]        pc = 64'd0;
    logic               imem_we = 1'b0;
    logic [IMEM_AW-1:0] imem_addr = '0;
    logic [7:0]         imem_wdata = 8'h00;
    logic               rf_we = 1'b0;
    logic [3:0]         rf_waddr = 4'h0;
    logic [63:0]        rf_wdata = 64'd0;
    logic [3:0]         icode, ifun, rA, rB;
    logic [63:0]        valC, valP, valA, valB;
    logic [2:0]         stat;
`ifdef REGDUMP_EN
    logic [1023:0]      reg_dump;
`endif

    y86_fetch_decode #(.IMEM_BYTES(IMEM_BYTES), .IMEM_AW(IMEM_AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc         (pc),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .icode      (icode),
        .ifun       (ifun),
        .rA         (rA),
        .rB         (rB),
        .valC       (valC),
        .valP       (valP),
        .valA       (valA),
        .valB       (valB),
`ifdef REGDUMP_EN
        .reg_dump   (reg_dump),
`endif
        .stat       (stat)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp, vala, valb;
        logic [2:0]  stat;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t mk(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                                input logic [3:0] rb, input logic [63:0] c, input logic [63:0] p,
                                input logic [63:0] a, input logic [63:0] b, input logic [2:0] s);
        exp_t e;
        e = {ic, fn, ra, rb, c, p, a, b, s};
        return e;
    endfunction

    function automatic exp_t obs();
        exp_t g;
        g = {icode, ifun, rA, rB, valC, valP, valA, valB, stat};
        return g;
    endfunction

    task automatic wbyte(input int a, input logic [7:0] d);
        imem_we    = 1'b1;
        imem_addr  = IMEM_AW'(a);
        imem_wdata = d;
        @(posedge clk); #1;
        imem_we    = 1'b0;
    endtask

    task automatic load(input int base, input int n, input logic [79:0] v);
        for (int i = 0; i < n; i++) begin
            wbyte(base + i, v[8*(n-1-i) +: 8]);
        end
    endtask

    task automatic rf_write(input logic [3:0] idx, input logic [63:0] d);
        rf_we = 1'b1; rf_waddr = idx; rf_wdata = d;
        @(posedge clk); #1;
        rf_we = 1'b0;
    endtask

    task automatic step(input logic [63:0] p, input exp_t e);
        sbq.push_back(e);
        pc = p;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        exp_t e, g;
        #1 rst_n = 1'b0;
        #1;
        e = mk(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 64'd0, 64'd0, 3'd1);
        g = obs();
        total++;
        if (g !== e) begin bad++; $display("FAIL reset got=%h want=%h", g, e); end
        for (int i = 0; i < IMEM_BYTES; i++) wbyte(i, 8'h10);
        load(0,    10, 80'h30F20A00000000000000);
        load(10,   2,  80'h6023);
        load(12,   2,  80'hA05F);
        load(14,   9,  80'h804000000000000000);
        load(23,   1,  80'h00);
        load(24,   1,  80'hC0);
        load(25,   2,  80'h2071);
        load(27,   2,  80'h600E);
        load(29,   2,  80'h2071);
        load(1014, 10, 80'h30F30807060504030201);
        #2 rst_n = 1'b1;
        #1;
        total++;
        if (valA !== 64'd0 || valB !== 64'd0 || icode !== 4'h1) begin
            bad++; $display("FAIL reset_release valA=%h valB=%h icode=%h want 0 0 1", valA, valB, icode);
        end
    endtask

    task automatic test_irmovq();
        exp_t e, g;
        step(64'd0, mk(4'h3, 4'h0, 4'hF, 4'h2, 64'd10, 64'd10, 64'd0, 64'd0, 3'd1));
        e = sbq.pop_front(); g = obs(); total++;
        if (g !== e) begin bad++; $display("FAIL irmovq got=%h want=%h", g, e); end
    endtask

    task automatic test_addq();
        exp_t e, g;
        step(64'd10, mk(4'h6, 4'h0, 4'h2, 4'h3, 64'd0, 64'd12, 64'd2, 64'd3, 3'd1));
        e = sbq.pop_front(); g = obs(); total++;
        if (g !== e) begin bad++; $display("FAIL addq got=%h want=%h", g, e); end
    endtask

    task automatic test_stack();
        exp_t e, g;
        step(64'd12, mk(4'hA, 4'h0, 4'h5, 4'hF, 64'd0, 64'd14, 64'd5, 64'd4, 3'd1));
        e = sbq.pop_front(); g = obs(); total++;
        if (g !== e) begin bad++; $display("FAIL pushq got=%h want=%h", g, e); end
        step(64'd14, mk(4'h8, 4'h0, 4'hF, 4'hF, 64'h40, 64'd23, 64'd0, 64'd4, 3'd1));
        e = sbq.pop_front(); g = obs(); total++;
        if (g !== e) begin bad++; $display("FAIL call got=%h want=%h", g, e); end
    endtask

    task automatic test_status();
        exp_t e, g;
        step(64'd23, mk(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd24, 64'd0, 64'd0, 3'd2));
        e = sbq.pop_front(); g = obs(); total++;
        if (g !== e) begin bad++; $display("FAIL halt got=%h want=%h", g, e); end
        step(64'd24, mk(4'hC, 4'h0, 4'hF, 4'hF, 64'd0, 64'd25, 64'd0, 64'd0, 3'd4));
        e = sbq.pop_front(); g = obs(); total++;
        if (g !== e) begin bad++; $display("FAIL invalid got=%h want=%h", g, e); end
        step(64'd1014, mk(4'h3, 4'h0, 4'hF, 4'h3, 64'h0102030405060708, 64'd1024, 64'd0, 64'd0, 3'd1));
        e = sbq.pop_front(); g = obs(); total++;
        if (g !== e) begin bad++; $display("FAIL irmovq_last got=%h want=%h", g, e); end
        wbyte(1023, 8'h00);
        step(64'd1023, mk(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1024, 64'd0, 64'd0, 3'd2));
        e = sbq.pop_front(); g = obs(); total++;
        if (g !== e) begin bad++; $display("FAIL halt_last got=%h want=%h", g, e); end
        wbyte(1019, 8'h30);
        step(64'd1019, mk(4'h3, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1029, 64'd0, 64'd0, 3'd3));
        e = sbq.pop_front(); total++;
        if (stat !== e.stat) begin bad++; $display("FAIL adr_stat got=%0d want=%0d", stat, e.stat); end
        total++;
        if (valC !== e.valc) begin bad++; $display("FAIL adr_valc got=%h want=%h", valC, e.valc); end
        step(64'd1047, mk(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1048, 64'd0, 64'd0, 3'd3));
        e = sbq.pop_front(); total++;
        if (stat !== e.stat) begin bad++; $display("FAIL adr_over_hlt got=%0d want=%0d", stat, e.stat); end
        step(64'd1048, mk(4'hC, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1049, 64'd0, 64'd0, 3'd3));
        e = sbq.pop_front(); total++;
        if (stat !== e.stat) begin bad++; $display("FAIL adr_over_ins got=%0d want=%0d", stat, e.stat); end
    endtask

    task automatic test_regwrite();
        exp_t e, g;
        rf_write(4'd7, 64'hDEAD);
        step(64'd25, mk(4'h2, 4'h0, 4'h7, 4'h1, 64'd0, 64'd27, 64'hDEAD, 64'd0, 3'd1));
        e = sbq.pop_front(); g = obs(); total++;
        if (g !== e) begin bad++; $display("FAIL rrmovq_r7 got=%h want=%h", g, e); end
        rf_we = 1'b1; rf_waddr = 4'd7; rf_wdata = 64'hBEEF;
        #1; total++;
        if (valA !== 64'hDEAD) begin bad++; $display("FAIL no_bypass got=%h want=%h", valA, 64'hDEAD); end
        @(posedge clk); #1;
        rf_we = 1'b0; total++;
        if (valA !== 64'hBEEF) begin bad++; $display("FAIL write_lands got=%h want=%h", valA, 64'hBEEF); end
        rf_write(4'hF, 64'h1234);
        step(64'd27, mk(4'h6, 4'h0, 4'h0, 4'hE, 64'd0, 64'd29, 64'd0, 64'd14, 3'd1));
        e = sbq.pop_front(); g = obs(); total++;
        if (g !== e) begin bad++; $display("FAIL write_rnone got=%h want=%h", g, e); end
    endtask

    task automatic test_imem_same_cycle();
        exp_t e, g;
        sbq.push_back(mk(4'h2, 4'h0, 4'h7, 4'h1, 64'd0, 64'd27, 64'hBEEF, 64'd0, 3'd1));
        pc = 64'd25;
        imem_we = 1'b1; imem_addr = 10'd25; imem_wdata = 8'h00;
        @(posedge clk); #1;
        imem_we = 1'b0;
        e = sbq.pop_front(); g = obs(); total++;
        if (g !== e) begin bad++; $display("FAIL imem_old_byte got=%h want=%h", g, e); end
        step(64'd25, mk(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd26, 64'd0, 64'd0, 3'd2));
        e = sbq.pop_front(); g = obs(); total++;
        if (g !== e) begin bad++; $display("FAIL imem_new_byte got=%h want=%h", g, e); end
    endtask

    task automatic test_reset_mid();
        exp_t e, g;
        rst_n = 1'b0;
        #1;
        e = mk(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 64'd0, 64'd0, 3'd1);
        g = obs(); total++;
        if (g !== e) begin bad++; $display("FAIL reset_mid got=%h want=%h", g, e); end
        #1 rst_n = 1'b1;
        step(64'd29, mk(4'h2, 4'h0, 4'h7, 4'h1, 64'd0, 64'd31, 64'd7, 64'd0, 3'd1));
        e = sbq.pop_front(); g = obs(); total++;
        if (g !== e) begin bad++; $display("FAIL reset_mid_regs got=%h want=%h", g, e); end
    endtask

    task automatic test_back_to_back();
        exp_t e, g;
        logic [63:0] pcs [4];
        exp_t        exps [4];
        pcs[0] = 64'd0;  exps[0] = mk(4'h3, 4'h0, 4'hF, 4'h2, 64'd10, 64'd10, 64'd0, 64'd0, 3'd1);
        pcs[1] = 64'd10; exps[1] = mk(4'h6, 4'h0, 4'h2, 4'h3, 64'd0, 64'd12, 64'd2, 64'd3, 3'd1);
        pcs[2] = 64'd12; exps[2] = mk(4'hA, 4'h0, 4'h5, 4'hF, 64'd0, 64'd14, 64'd5, 64'd4, 3'd1);
        pcs[3] = 64'd14; exps[3] = mk(4'h8, 4'h0, 4'hF, 4'hF, 64'h40, 64'd23, 64'd0, 64'd4, 3'd1);
        for (int i = 0; i < 4; i++) begin
            step(pcs[i], exps[i]);
            e = sbq.pop_front(); g = obs(); total++;
            if (g !== e) begin bad++; $display("FAIL b2b_%0d got=%h want=%h", i, g, e); end
        end
    endtask

    initial begin
        test_reset();
        test_irmovq();
        test_addq();
        test_stack();
        test_status();
        test_regwrite();
        test_imem_same_cycle();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
